// File: rtl/i_cache_2way_param_pkg.sv
// icache_pkg: shared types and helpers for the parametrised 2-way I-cache.
//   state_e    : controller state (IDLE, REFILL, RESP), 2-bit encoding
//   way_t      : index of one of the two ways
//   sel_victim : way chosen for a refill (first invalid way, else LRU)
//   NUM_SETS / BLK_W : geometry of the default configuration
package icache_pkg;

  localparam int DEF_SET_BITS = 2;
  localparam int DEF_OFF_BITS = 2;
  localparam int NUM_SETS     = 1 << DEF_SET_BITS;
  localparam int BLK_W        = 32 << DEF_OFF_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic way_t;

  // An empty way is always preferred, way 0 first; only a full set uses LRU.
  function automatic way_t sel_victim(input logic valid0, input logic valid1, input logic lru);
    way_t v;
    if (!valid0) begin
      v = 1'b0;
    end else if (!valid1) begin
      v = 1'b1;
    end else begin
      v = lru;
    end
    return v;
  endfunction

endpackage

// File: rtl/i_cache_2way_param_chk.sv
// icache_chk: simulation checks for the I-cache controller.
//   clk_i, rst_i : clock and synchronous reset
//   lookup_i     : a tag lookup is being evaluated this cycle
//   hit0_i/hit1_i: per-way tag match
module icache_chk (
  input logic clk_i,
  input logic rst_i,
  input logic lookup_i,
  input logic hit0_i,
  input logic hit1_i
);

  // The same tag may never live in both ways of a set.
  a_single_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    !(lookup_i && hit0_i && hit1_i));

endmodule

// File: rtl/i_cache_2way_param_way_array.sv
// icache_way_array: valid/tag/data storage for both ways of every set.
//   clk_i, rst_i        : clock, synchronous active-high reset (clears valid bits)
//   clr_i               : invalidate every line at the next edge
//   we_i, wway_i, wset_i, wtag_i, wdata_i : single line write port
//   rset_i              : set read combinationally from both ways
//   rvalid*_o, rtag*_o, rdata*_o : per-way contents of set rset_i
module icache_way_array #(
  parameter int SET_BITS = 2,
  parameter int TAG_W    = 26,
  parameter int LINE_W   = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic                wway_i,
  input  logic [SET_BITS-1:0] wset_i,
  input  logic [TAG_W-1:0]    wtag_i,
  input  logic [LINE_W-1:0]   wdata_i,
  input  logic [SET_BITS-1:0] rset_i,
  output logic                rvalid0_o,
  output logic                rvalid1_o,
  output logic [TAG_W-1:0]    rtag0_o,
  output logic [TAG_W-1:0]    rtag1_o,
  output logic [LINE_W-1:0]   rdata0_o,
  output logic [LINE_W-1:0]   rdata1_o
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid0_q;
  logic [SETS-1:0]   valid1_q;
  logic [TAG_W-1:0]  tag0_q  [SETS];
  logic [TAG_W-1:0]  tag1_q  [SETS];
  logic [LINE_W-1:0] data0_q [SETS];
  logic [LINE_W-1:0] data1_q [SETS];

  // Valid bits: reset and invalidate take priority over a line write.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      valid0_q <= '0;
      valid1_q <= '0;
    end else if (we_i) begin
      if (wway_i) begin
        valid1_q[wset_i] <= 1'b1;
      end else begin
        valid0_q[wset_i] <= 1'b1;
      end
    end else begin
      valid0_q <= valid0_q;
      valid1_q <= valid1_q;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (wway_i) begin
        tag1_q[wset_i]  <= wtag_i;
        data1_q[wset_i] <= wdata_i;
      end else begin
        tag0_q[wset_i]  <= wtag_i;
        data0_q[wset_i] <= wdata_i;
      end
    end
  end

  assign rvalid0_o = valid0_q[rset_i];
  assign rvalid1_o = valid1_q[rset_i];
  assign rtag0_o   = tag0_q[rset_i];
  assign rtag1_o   = tag1_q[rset_i];
  assign rdata0_o  = data0_q[rset_i];
  assign rdata1_o  = data1_q[rset_i];

endmodule

// File: rtl/i_cache_2way_param.sv
// i_cache_2way_param: read-only 2-way set-associative instruction cache.
// Optional feature macro: ICACHE_PERF_CNT_EN (adds perf_hit / perf_miss).
//   clk, proc_reset           : clock, synchronous active-high reset
//   proc_read, proc_addr      : fetch request (word address {tag,set,offset})
//   proc_write, proc_wdata    : ignored, cache is read-only
//   proc_flush                : one-cycle pulse invalidating every line
//   proc_rdata, proc_stall    : fetched word, valid when proc_read && !proc_stall
//   mem_read, mem_addr        : block read request {tag,set}, held until mem_ready
//   mem_write                 : tied low
//   mem_rdata, mem_ready      : returned block and its completion strobe
//   perf_hit, perf_miss       : saturating hit / miss counters (macro only)
module i_cache_2way_param
  import icache_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int SET_BITS = DEF_SET_BITS,
  parameter int OFF_BITS = DEF_OFF_BITS
) (
  input  logic                       clk,
  input  logic                       proc_reset,
  input  logic                       proc_read,
  input  logic                       proc_write,
  input  logic [ADDR_W-1:0]          proc_addr,
  input  logic [31:0]                proc_wdata,
  input  logic                       proc_flush,
  output logic [31:0]                proc_rdata,
  output logic                       proc_stall,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-OFF_BITS-1:0] mem_addr,
  input  logic [(32<<OFF_BITS)-1:0]  mem_rdata,
  input  logic                       mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                perf_hit,
  output logic [31:0]                perf_miss
`endif
);

  localparam int TAG_W  = ADDR_W - SET_BITS - OFF_BITS;
  localparam int SETS_N = 1 << SET_BITS;
  localparam int LINE_W = 32 << OFF_BITS;

  state_e                state_q, state_d;
  logic [TAG_W-1:0]      req_tag_q, req_tag_d;
  logic [SET_BITS-1:0]   req_set_q, req_set_d;
  logic [OFF_BITS-1:0]   req_off_q, req_off_d;
  way_t                  victim_q, victim_d;
  logic [LINE_W-1:0]     buf_q, buf_d;
  logic [SETS_N-1:0]     lru_q, lru_d;
  logic                  flush_pend_q, flush_pend_d;

  logic [TAG_W-1:0]      addr_tag_s;
  logic [SET_BITS-1:0]   addr_set_s;
  logic [OFF_BITS-1:0]   addr_off_s;
  logic                  rvalid0_s, rvalid1_s;
  logic [TAG_W-1:0]      rtag0_s, rtag1_s;
  logic [LINE_W-1:0]     rdata0_s, rdata1_s;
  logic                  hit0_s, hit1_s;
  logic [LINE_W-1:0]     hit_line_s;
  logic                  we_s, clr_s;
  logic                  hit_evt_s, miss_evt_s;
  logic                  lookup_s;
  logic                  unused_ok;

  assign addr_tag_s = proc_addr[ADDR_W-1 -: TAG_W];
  assign addr_set_s = proc_addr[OFF_BITS +: SET_BITS];
  assign addr_off_s = proc_addr[OFF_BITS-1:0];

  icache_way_array #(
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_ways (
    .clk_i     (clk),
    .rst_i     (proc_reset),
    .clr_i     (clr_s),
    .we_i      (we_s),
    .wway_i    (victim_q),
    .wset_i    (req_set_q),
    .wtag_i    (req_tag_q),
    .wdata_i   (buf_q),
    .rset_i    (addr_set_s),
    .rvalid0_o (rvalid0_s),
    .rvalid1_o (rvalid1_s),
    .rtag0_o   (rtag0_s),
    .rtag1_o   (rtag1_s),
    .rdata0_o  (rdata0_s),
    .rdata1_o  (rdata1_s)
  );

  assign hit0_s     = rvalid0_s && (rtag0_s == addr_tag_s);
  assign hit1_s     = rvalid1_s && (rtag1_s == addr_tag_s);
  assign hit_line_s = hit1_s ? rdata1_s : rdata0_s;
  assign lookup_s   = (state_q == IDLE) && proc_read && !flush_pend_q && !proc_flush;
  assign mem_write  = 1'b0;

  icache_chk u_chk (
    .clk_i    (clk),
    .rst_i    (proc_reset),
    .lookup_i (lookup_s),
    .hit0_i   (hit0_s),
    .hit1_i   (hit1_s)
  );

  // Next-state, line fill, LRU/flush bookkeeping and all processor/memory outputs.
  always_comb begin
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_set_d    = req_set_q;
    req_off_d    = req_off_q;
    victim_d     = victim_q;
    buf_d        = buf_q;
    lru_d        = lru_q;
    flush_pend_d = flush_pend_q;
    we_s         = 1'b0;
    clr_s        = 1'b0;
    hit_evt_s    = 1'b0;
    miss_evt_s   = 1'b0;
    proc_stall   = 1'b0;
    proc_rdata   = 32'h0000_0000;
    mem_read     = 1'b0;
    mem_addr     = '0;

    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          // A flush arrived during the last refill: wipe everything, including that line.
          proc_stall   = 1'b1;
          clr_s        = 1'b1;
          lru_d        = '0;
          flush_pend_d = 1'b0;
        end else begin
          if (proc_flush) begin
            clr_s = 1'b1;
            lru_d = '0;
          end else begin
            clr_s = 1'b0;
          end
          if (proc_read) begin
            if ((hit0_s || hit1_s) && !proc_flush) begin
              proc_rdata         = hit_line_s[{addr_off_s, 5'b00000} +: 32];
              lru_d[addr_set_s]  = ~hit1_s;
              hit_evt_s          = 1'b1;
            end else begin
              // A read coinciding with a flush sees an empty cache, so way 0 is free.
              proc_stall = 1'b1;
              req_tag_d  = addr_tag_s;
              req_set_d  = addr_set_s;
              req_off_d  = addr_off_s;
              victim_d   = proc_flush ? 1'b0 : sel_victim(rvalid0_s, rvalid1_s, lru_q[addr_set_s]);
              miss_evt_s = 1'b1;
              state_d    = REFILL;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      REFILL: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag_q, req_set_q};
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = RESP;
        end else begin
          state_d = REFILL;
        end
        if (proc_flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end
      RESP: begin
        we_s              = 1'b1;
        lru_d[req_set_q]  = ~victim_q;
        proc_rdata        = buf_q[{req_off_q, 5'b00000} +: 32];
        state_d           = IDLE;
        if (proc_flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, request latch, line buffer and LRU bits.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      req_tag_q    <= '0;
      req_set_q    <= '0;
      req_off_q    <= '0;
      victim_q     <= 1'b0;
      buf_q        <= '0;
      lru_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      req_set_q    <= req_set_d;
      req_off_q    <= req_off_d;
      victim_q     <= victim_d;
      buf_q        <= buf_d;
      lru_q        <= lru_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  // Saturating event counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      perf_hit_q  <= 32'h0000_0000;
      perf_miss_q <= 32'h0000_0000;
    end else begin
      if (hit_evt_s && (perf_hit_q != 32'hFFFF_FFFF)) begin
        perf_hit_q <= perf_hit_q + 32'd1;
      end else begin
        perf_hit_q <= perf_hit_q;
      end
      if (miss_evt_s && (perf_miss_q != 32'hFFFF_FFFF)) begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end else begin
        perf_miss_q <= perf_miss_q;
      end
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
  assign unused_ok = ^{proc_write, proc_wdata};
`else
  assign unused_ok = ^{proc_write, proc_wdata, hit_evt_s, miss_evt_s};
`endif

endmodule

// File: doc/i_cache_2way_param.md
Name: i_cache_2way_param

Overview:
- Parametrised read-only 2-way set-associative instruction cache, next generation of the fixed 4-set I-cache.
- Sits between the core fetch port (word-addressed) and the instruction memory (block-addressed, one block per transfer).
- Adds three things the previous generation lacks:
  - set count and block size as parameters;
  - a one-cycle-shorter miss path;
  - a whole-cache invalidate (fence.i) input.

Parameters:
- ADDR_W, 30, processor word-address width.
- SET_BITS, 2, log2 of number of sets (NUM_SETS = 2^SET_BITS).
- OFF_BITS, 2, log2 of 32-bit words per block (block width BLK_W = 32<<OFF_BITS).
- TAG_W, ADDR_W-SET_BITS-OFF_BITS, derived tag width; not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- proc_reset  in  1  synchronous active-high reset.
- proc_read  in  1  fetch request, held until proc_stall is low.
- proc_write  in  1  ignored (read-only cache); proc_wdata ignored.
- proc_addr  in  ADDR_W  word address {tag, set, offset}.
- proc_wdata  in  32  unused.
- proc_flush  in  1  single-cycle pulse: invalidate all lines.
- proc_rdata  out  32  instruction word, valid when proc_read && !proc_stall.
- proc_stall  out  1  high while a request cannot complete this cycle.
- mem_read  out  1  block read request, held until mem_ready.
- mem_write  out  1  tied 0.
- mem_addr  out  ADDR_W-OFF_BITS  block address {tag, set}.
- mem_rdata  in  BLK_W  block data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion strobe.

Behaviour:

Storage and reset:
- Per set: 2 ways × {valid, tag, data}, plus one LRU bit naming the next victim way.
- No dirty bits.
- Reset, synchronous, active-high:
  - state=IDLE; all valid=0; LRU=0; flush_pend=0.
  - proc_stall=0, mem_read=0, mem_addr=0, proc_rdata=0.
  - Outputs are combinational from state, so they reach these values in the cycle after the reset edge.

Lookup (IDLE, proc_read=1):
- hit_w = valid[w] && tag[w]==proc_addr tag.
- Hit (zero-wait):
  - proc_rdata = data word[offset] of the hitting way; proc_stall=0.
  - LRU[set] <= ~hitway.
- Both ways hitting is illegal; assert in simulation.
- Miss:
  - proc_stall=1.
  - Latch {tag, set, offset} into a request register.
  - Victim = first invalid way (way0 priority), else LRU[set].
  - Go to REFILL.

REFILL:
- mem_read=1; mem_addr = latched {tag, set}; proc_stall=1.
- On mem_ready: capture mem_rdata into the line buffer; go to RESP.
- No timeout.

RESP (exactly one cycle):
- Write the victim line: valid=1, latched tag, buffer data.
- LRU[set] <= ~victim.
- proc_stall=0; proc_rdata = buffer word[latched offset]; go to IDLE.
- Miss latency: request cycle + memory wait + 1.
- proc_addr must be stable from the request until completion.

Idle with no request:
- proc_stall=0; proc_rdata=0.

Flush:
- proc_flush in IDLE: all valid and LRU cleared at the next edge. A coincident proc_read in that cycle is treated as a miss and its refill proceeds normally.
- proc_flush in REFILL or RESP: set flush_pend.
  - The in-flight refill still completes and returns its data.
  - The filled line is then invalidated, with all others, on the first IDLE cycle (during which proc_stall=1).

Reset mid-refill:
- Everything returns to reset values and mem_read drops.
- A late mem_ready in IDLE is ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_hit[31:0] and perf_miss[31:0].
  - perf_hit increments on each IDLE hit; perf_miss increments on each IDLE miss transition.
  - Both counters saturate at 0xFFFFFFFF and are cleared by proc_reset; proc_flush does not clear them.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, REFILL, RESP} (2 bits);
  - way index type;
  - function for victim selection;
  - localparams BLK_W, NUM_SETS.
- One natural sub-module, icache_way_array: per-way valid/tag/data storage with one write port and a combinational read of both ways, instantiated once.
- The FSM, LRU, flush logic and counters stay in the top module.

Test Plan:
- Cold miss: reset, read addr 0x00000010, memory returns 128'h…4444_3333_2222_1111 after 3 cycles -> stall high for 5 cycles, then rdata=0x11111111 with stall low.
- Re-read 0x00000011 next cycle -> hit, stall low same cycle, rdata=0x22222222.
- LRU eviction on set 0:
  - Fill tag A, then tag B.
  - Hit A -> next miss on tag C replaces B.
  - Re-read A hits; re-read B misses.
- Flush in IDLE after filling 2 lines -> both next reads miss with mem_read asserted.
- Flush pulsed during REFILL -> data still returned in RESP; immediate re-read of the same address misses.
- Reset asserted mid-REFILL -> mem_read low, stall low in the following cycle; a stray mem_ready is ignored and the cache stays empty.
- With ICACHE_PERF_CNT_EN defined: after the above sequence, perf_hit and perf_miss match the scoreboard count.
